// File: rtl/cnt_pkg.sv
// Shared types and default parameter values for the up/down counter block.
package cnt_pkg;

  // Behaviour at the counting boundary: wrap around or stick at the bound.
  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

  localparam int CNT_N_DEF     = 8;
  localparam int CNT_PRE_W_DEF = 4;

endpackage

// File: rtl/cnt_prescaler.sv
// Enable prescaler: emits one tick every div+1 enabled cycles.
// The phase counter holds while en is low, and clr restarts the period.
module cnt_prescaler
  import cnt_pkg::*;
#(
  parameter int PRE_W = CNT_PRE_W_DEF
) (
  input  logic             Clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] div,
  output logic             tick
);

  localparam logic [PRE_W-1:0] PC_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

  logic [PRE_W-1:0] pc_reg;
  logic [PRE_W-1:0] pc_next;

  // Tick is combinational so the counter steps on the same edge as the tick.
  assign tick = en && (pc_reg == div);

  // Next phase: clear wins, a tick returns to 0, otherwise advance while enabled.
  always_comb begin
    pc_next = pc_reg;
    if (clr) begin
      pc_next = '0;
    end else if (tick) begin
      pc_next = '0;
    end else if (en) begin
      pc_next = pc_reg + PC_ONE;
    end
  end

  // Phase register, cleared asynchronously so a reset abandons a partial period.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      pc_reg <= '0;
    end else begin
      pc_reg <= pc_next;
    end
  end

endmodule

// File: rtl/cnt_updn_mod.sv
// Prescaled up/down counter over the range 0..lim with wrap or saturate
// behaviour at the bounds, synchronous load and a terminal-count pulse.
module cnt_updn_mod
  import cnt_pkg::*;
#(
  parameter int n     = CNT_N_DEF,
  parameter int PRE_W = CNT_PRE_W_DEF
) (
  input  logic             Clk,
  input  logic             resetn,
  input  logic             en,
  input  logic             ld,
  input  logic [n-1:0]     D,
  input  logic             up,
  input  logic             mode,
  input  logic [n-1:0]     lim,
  input  logic [PRE_W-1:0] pre_div,
  output logic [n-1:0]     q,
  output logic             tc,
  output logic             at_bnd
);

  localparam logic [n-1:0] Q_ONE = {{(n-1){1'b0}}, 1'b1};

  cnt_mode_e    mode_sel;
  logic         tick;
  logic [n-1:0] q_reg;
  logic [n-1:0] q_next;
  logic         tc_reg;
  logic         tc_next;

  assign mode_sel = cnt_mode_e'(mode);

  // A load restarts the prescale period so the next step needs a full period.
  cnt_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .Clk    (Clk),
    .resetn (resetn),
    .en     (en),
    .clr    (ld),
    .div    (pre_div),
    .tick   (tick)
  );

  // Boundary flag follows the current direction; q above lim counts as at the top.
  assign at_bnd = (up && (q_reg >= lim)) || (!up && (q_reg == '0));

  // Next count and terminal-count pulse; load overrides any pending tick.
  always_comb begin
    q_next  = q_reg;
    tc_next = 1'b0;
    if (ld) begin
      q_next = (D > lim) ? lim : D;
    end else if (tick) begin
      if (up) begin
        if (q_reg < lim) begin
          q_next = q_reg + Q_ONE;
        end else begin
          q_next  = (mode_sel == CNT_WRAP) ? '0 : lim;
          tc_next = 1'b1;
        end
      end else begin
        if (q_reg != '0) begin
          // Saturating mode pulls an out-of-range count straight back to lim.
          if ((mode_sel == CNT_SAT) && (q_reg > lim)) begin
            q_next = lim;
          end else begin
            q_next = q_reg - Q_ONE;
          end
        end else begin
          q_next  = (mode_sel == CNT_WRAP) ? lim : '0;
          tc_next = 1'b1;
        end
      end
    end
  end

  // Count and pulse registers with asynchronous active-low clear.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      q_reg  <= '0;
      tc_reg <= 1'b0;
    end else begin
      q_reg  <= q_next;
      tc_reg <= tc_next;
    end
  end

  assign q  = q_reg;
  assign tc = tc_reg;

endmodule
